// File: rtl/input_debouncer_pkg.sv
// Shared debounce constants: 1 ms window at 50 MHz for silicon, short window for benches.
`timescale 1ns/1ps
package input_debouncer_pkg;

    localparam int DEBOUNCE_CNT_1MS = 50000;
    localparam int SIM_DEBOUNCE_CNT = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level; 2-cycle latency, no backpressure.
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Per-bit button debouncer: output follows the synchronised input after CNT_MAX stable cycles
// (CNT_MAX+2 edges from raw change). Optional rise/fall pulses under `DEBOUNCE_PULSE_EN.
`timescale 1ns/1ps
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int CNT_MAX = DEBOUNCE_CNT_1MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_out,
    output logic             busy,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int                CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] out_nxt;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic             busy_nxt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_sync
        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d   (btn_in[g]),
            .q   (sync[g])
        );
    end

    // Any cycle where the synchronised level matches the output restarts the window.
    always_comb begin
        out_nxt  = btn_out;
        busy_nxt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync[i] != btn_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    out_nxt[i] = sync[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
            busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_out <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_out <= out_nxt;
            busy    <= busy_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef DEBOUNCE_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= out_nxt & ~btn_out;
            fall <= ~out_nxt & btn_out;
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
